fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the EX-stage forwarding unit. It tracks in-flight register writers in a shadow pipeline of FWD_STAGES stages. It registers one forwarding select per operand for the instruction entering EX. It also generates load-use stalls and multi-cycle-op freezes. It sits beside the ID/EX pipeline register and is driven from the ID-stage decode.

Parameters:
ADDR_WIDTH, 5, register address width
NUM_OPS, 2, source operands per instruction
FWD_STAGES, 2, forwardable stages after EX (1=MEM, 2=WB, ...); range 2..6
MUL_LATENCY, 3, EX occupancy in cycles of a multi-cycle op; range 1..15
SEL_W, derived clog2(FWD_STAGES+1), width of each select

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
ID_VALID  in  1  ID holds a real instruction
ID_ADDR  in  NUM_OPS*ADDR_WIDTH  source addresses; operand i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
ID_DEST  in  ADDR_WIDTH  destination address
ID_WRITE_EN  in  1  instruction writes ID_DEST
ID_IS_LOAD  in  1  result available only after MEM
ID_IS_MULTI  in  1  multi-cycle EX op
FLUSH  in  1  kill ID instruction (branch taken in EX)
STALL  out  1  hold PC and IF/ID, bubble into EX (combinational)
FREEZE  out  1  hold entire pipeline (combinational from counter)
EX_FWD_SEL  out  NUM_OPS*SEL_W  per-operand select for the EX instruction (registered); 0=regfile, k=stage k

Behaviour:
- Shadow tags T[0..FWD_STAGES]: T[0]=EX, T[k]=k stages after EX. Each tag holds {valid, wen, load, dest}.
- Reset (RESET low, async): all tags invalid, EX_FWD_SEL=0, freeze counter=0, STALL=0, FREEZE=0.
- FREEZE=1 while freeze counter != 0.
  - No tag shifts, EX_FWD_SEL held, counter decrements.
  - STALL forced 0.
- Load-use STALL=1 when all of: ID_VALID, !FLUSH, !FREEZE, T[0].valid, T[0].wen, T[0].load, T[0].dest != 0, and any ID operand equals T[0].dest.
- Normal edge (FREEZE=0): T[k] <= T[k-1] for k=1..FWD_STAGES, and T[FWD_STAGES] drops off.
  - T[0] <= ID entry, unless STALL, FLUSH or !ID_VALID; in those cases T[0] <= bubble (valid=0).
  - Same-edge EX_FWD_SEL computation, per operand i: smallest k in 1..FWD_STAGES with T[k-1] valid, wen, dest==operand and dest != 0 gives sel=k.
  - A load in T[0] never matches at k=1; the stall covers that case.
  - If no stage matches, sel=0.
  - On a bubble insert, EX_FWD_SEL <= 0.
- Nearest stage wins (generalises MEM-over-WB priority). Address 0 never forwards.
- Multi-cycle op: when an ID_IS_MULTI entry moves into T[0], the counter loads MUL_LATENCY-1. FREEZE therefore lasts exactly MUL_LATENCY-1 cycles. With MUL_LATENCY=1 there is no freeze.
- Simultaneous events: FREEZE has priority over STALL and FLUSH. FLUSH during FREEZE is ignored; the source re-asserts it after the freeze.
- FLUSH suppresses STALL.
- Reset mid-freeze or mid-stall: immediate clear. The first post-reset edge behaves as an empty pipeline.
- Outputs are X-free after reset. Compares use only valid tags.

Test Plan:
1. Defaults. ALU writes x11 enters EX; next ID reads x11 (op0) and x17 (op1) -> EX_FWD_SEL op0=1, op1=0; STALL=0.
2. Two writers to x11 one cycle apart, then a reader of x11 -> sel=1 (nearest). Remove the younger writer -> sel=2. FWD_STAGES=4 build: writer 4 ahead -> sel=4, 5 ahead -> sel=0.
3. Load to x5 in EX, ID reads x5 -> STALL=1 for exactly one cycle, T[0] bubble. Dependent then enters EX with sel=2. Same test with ID reading x0 -> STALL=0, sel=0.
4. MUL_LATENCY=3: multi op enters EX -> FREEZE=1 for 2 cycles, EX_FWD_SEL held. A load-use pair in ID during the freeze gives STALL=0 until the freeze ends, then STALL=1.
5. FLUSH while ID reads a load's destination -> STALL=0, bubble inserted, EX_FWD_SEL=0.
6. Assert RESET low mid-freeze (counter=1) -> FREEZE, STALL, EX_FWD_SEL go 0 without a clock edge. After release, a reader of a previous writer gets sel=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage forwarding select, load-use stall and
// multi-cycle-op freeze. A shadow pipeline of writer tags mirrors the
// EX stage and the forwardable stages after it.

// Per-operand compare: finds the nearest forwarding stage for one source
// and flags a load-use hit against the load currently in EX.
module fwd_hazard_opsel #(
    parameter int ADDR_WIDTH = 5,
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = 2
) (
    input  logic [ADDR_WIDTH-1:0]                  i_op,
    input  logic [FWD_STAGES-1:0]                  i_vld,
    input  logic [FWD_STAGES-1:0]                  i_wen,
    input  logic                                   i_ld0,
    input  logic [FWD_STAGES-1:0][ADDR_WIDTH-1:0]  i_dest,
    output logic [SEL_W-1:0]                       o_sel,
    output logic                                   o_use
);

    // Walk from the oldest stage to the youngest so the nearest match wins.
    // Stage k forwards from the tag that is currently at T[k-1]. A load in
    // EX cannot forward to the next instruction; the stall covers that.
    always_comb begin
        o_sel = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (i_vld[k-1] && i_wen[k-1] && (i_op != '0) &&
                (i_dest[k-1] == i_op) && !((k == 1) && i_ld0))
                o_sel = SEL_W'(k);
        end
    end

    // Load-use hit: the producer in EX is a load whose result is not ready.
    assign o_use = i_vld[0] && i_wen[0] && i_ld0 &&
                   (i_dest[0] != '0) && (i_dest[0] == i_op);

endmodule

module fwd_hazard_unit #(
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_OPS     = 2,
    parameter int FWD_STAGES  = 2,
    parameter int MUL_LATENCY = 3,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ID_VALID,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0] ID_ADDR,
    input  logic [ADDR_WIDTH-1:0]         ID_DEST,
    input  logic                          ID_WRITE_EN,
    input  logic                          ID_IS_LOAD,
    input  logic                          ID_IS_MULTI,
    input  logic                          FLUSH,
    output logic                          STALL,
    output logic                          FREEZE,
    output logic [NUM_OPS*SEL_W-1:0]      EX_FWD_SEL
);

    // MUL_LATENCY tops out at 15, so the countdown never exceeds 14.
    localparam int CNT_W = 4;

    // Shadow tags T[0..FWD_STAGES-1]. The oldest tag T[FWD_STAGES] is never
    // compared against, so it is not stored. The load flag only matters
    // while the tag sits in EX, so it is kept for T[0] alone.
    logic [FWD_STAGES-1:0]                 r_vld;
    logic [FWD_STAGES-1:0]                 r_wen;
    logic [FWD_STAGES-1:0][ADDR_WIDTH-1:0] r_dest;
    logic                                  r_ld0;
    logic [CNT_W-1:0]                      r_cnt;
    logic [NUM_OPS-1:0][SEL_W-1:0]         r_sel;

    logic [NUM_OPS-1:0][SEL_W-1:0]         w_sel;
    logic [NUM_OPS-1:0]                    w_use;
    logic                                  w_freeze;
    logic                                  w_stall;
    logic                                  w_ins;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
            fwd_hazard_opsel #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .FWD_STAGES (FWD_STAGES),
                .SEL_W      (SEL_W)
            ) u_opsel (
                .i_op   (ID_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .i_vld  (r_vld),
                .i_wen  (r_wen),
                .i_ld0  (r_ld0),
                .i_dest (r_dest),
                .o_sel  (w_sel[gi]),
                .o_use  (w_use[gi])
            );
        end
    endgenerate

    assign w_freeze = (r_cnt != '0);
    // A freeze or a flush overrides the load-use stall.
    assign w_stall  = ID_VALID && !FLUSH && !w_freeze && (|w_use);
    // ID instruction actually advances into EX on a normal edge.
    assign w_ins    = ID_VALID && !FLUSH && !w_stall;

    assign STALL      = w_stall;
    assign FREEZE     = w_freeze;
    assign EX_FWD_SEL = r_sel;

    // Tag shift, EX select capture and freeze countdown. A frozen edge only
    // counts down; everything else holds.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_vld  <= '0;
            r_wen  <= '0;
            r_dest <= '0;
            r_ld0  <= 1'b0;
            r_cnt  <= '0;
            r_sel  <= '0;
        end else if (w_freeze) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                r_vld[k]  <= r_vld[k-1];
                r_wen[k]  <= r_wen[k-1];
                r_dest[k] <= r_dest[k-1];
            end
            r_vld[0]  <= w_ins;
            r_wen[0]  <= w_ins && ID_WRITE_EN;
            r_dest[0] <= w_ins ? ID_DEST : '0;
            r_ld0     <= w_ins && ID_IS_LOAD;
            r_sel     <= w_ins ? w_sel : '0;
            if (w_ins && ID_IS_MULTI)
                r_cnt <= CNT_W'(MUL_LATENCY - 1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit at default parameters
// (5-bit addresses, 2 operands, 2 forwarding stages, MUL_LATENCY=3).
// EX_FWD_SEL is compared as {op1_sel, op0_sel}, two bits each.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NO = 2;
    localparam int FS = 2;
    localparam int ML = 3;
    localparam int SW = 2;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             ID_VALID = 1'b0;
    logic [NO*AW-1:0] ID_ADDR = '0;
    logic [AW-1:0]    ID_DEST = '0;
    logic             ID_WRITE_EN = 1'b0;
    logic             ID_IS_LOAD = 1'b0;
    logic             ID_IS_MULTI = 1'b0;
    logic             FLUSH = 1'b0;
    logic             STALL;
    logic             FREEZE;
    logic [NO*SW-1:0] EX_FWD_SEL;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fwd_hazard_unit #(
        .ADDR_WIDTH  (AW),
        .NUM_OPS     (NO),
        .FWD_STAGES  (FS),
        .MUL_LATENCY (ML)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ID_VALID    (ID_VALID),
        .ID_ADDR     (ID_ADDR),
        .ID_DEST     (ID_DEST),
        .ID_WRITE_EN (ID_WRITE_EN),
        .ID_IS_LOAD  (ID_IS_LOAD),
        .ID_IS_MULTI (ID_IS_MULTI),
        .FLUSH       (FLUSH),
        .STALL       (STALL),
        .FREEZE      (FREEZE),
        .EX_FWD_SEL  (EX_FWD_SEL)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Present one ID-stage instruction, then settle the combinational outputs.
    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [AW-1:0] d, input logic w, input logic ld,
                         input logic mul, input logic fl);
        ID_VALID    = v;
        ID_ADDR     = {s1, s0};
        ID_DEST     = d;
        ID_WRITE_EN = w;
        ID_IS_LOAD  = ld;
        ID_IS_MULTI = mul;
        FLUSH       = fl;
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        idle();
        tick();
        tick();
        chk("rst_stall", STALL, 0);
        chk("rst_freeze", FREEZE, 0);
        chk("rst_sel", EX_FWD_SEL, 0);
        #2 RESET = 1'b1;

        // ALU writer x11 in EX, reader of x11/x17 gets op0 from stage 1
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        drive(1, 11, 17, 3, 0, 0, 0, 0);
        chk("t1_stall", STALL, 0);
        tick();
        chk("t1_sel", EX_FWD_SEL, 4'h1);
        idle(); tick();
        chk("t1_bubble_sel", EX_FWD_SEL, 0);
        idle(); tick();

        // Two writers to x11: the younger one wins
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        drive(1, 11, 0, 3, 0, 0, 0, 0); tick();
        chk("t2_nearest", EX_FWD_SEL, 4'h1);
        // Younger instruction names x11 but does not write: fall back to stage 2 (op1)
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 11, 0, 0, 0, 0); tick();
        drive(1, 0, 11, 3, 0, 0, 0, 0); tick();
        chk("t2_stage2_op1", EX_FWD_SEL, 4'h8);
        // Both operands read the same writer
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        drive(1, 11, 11, 3, 0, 0, 0, 0); tick();
        chk("t2_both_ops", EX_FWD_SEL, 4'h5);
        // Writer three ahead has left the forwarding window
        drive(1, 0, 0, 11, 1, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();
        drive(1, 11, 0, 3, 0, 0, 0, 0); tick();
        chk("t2_aged_out", EX_FWD_SEL, 0);
        // Writes to x0 never forward
        drive(1, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 3, 0, 0, 0, 0); tick();
        chk("t2_x0", EX_FWD_SEL, 0);

        // Load-use: one stall cycle, bubble, then forward from stage 2
        drive(1, 0, 0, 5, 1, 1, 0, 0); tick();
        drive(1, 5, 2, 3, 0, 0, 0, 0);
        chk("t3_stall", STALL, 1);
        tick();
        chk("t3_bubble_sel", EX_FWD_SEL, 0);
        chk("t3_stall_once", STALL, 0);
        tick();
        chk("t3_sel", EX_FWD_SEL, 4'h2);
        // Load to x0, reader of x0: no stall, no forward
        drive(1, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        chk("t3_x0_stall", STALL, 0);
        tick();
        chk("t3_x0_sel", EX_FWD_SEL, 0);
        idle(); tick();

        // Multi-cycle load to x7 (itself forwarding x9): freeze 2 cycles, select held,
        // dependent stall deferred until the freeze ends
        drive(1, 0, 0, 9, 1, 0, 0, 0); tick();
        drive(1, 9, 0, 7, 1, 1, 1, 0);
        chk("t4_pre_freeze", FREEZE, 0);
        tick();
        chk("t4_multi_sel", EX_FWD_SEL, 4'h1);
        drive(1, 7, 0, 3, 0, 0, 0, 0);
        chk("t4_freeze_c1", FREEZE, 1);
        chk("t4_stall_c1", STALL, 0);
        tick();
        chk("t4_freeze_c2", FREEZE, 1);
        chk("t4_stall_c2", STALL, 0);
        chk("t4_sel_held", EX_FWD_SEL, 4'h1);
        tick();
        chk("t4_freeze_end", FREEZE, 0);
        chk("t4_stall_after", STALL, 1);
        chk("t4_sel_held2", EX_FWD_SEL, 4'h1);
        tick();
        chk("t4_stall_once", STALL, 0);
        chk("t4_bubble_sel", EX_FWD_SEL, 0);
        tick();
        chk("t4_dep_sel", EX_FWD_SEL, 4'h2);
        idle(); tick();
        idle(); tick();

        // Flush while ID reads a load result: no stall, bubble, select cleared
        drive(1, 0, 0, 12, 1, 0, 0, 0); tick();
        drive(1, 12, 0, 5, 1, 1, 0, 0); tick();
        chk("t5_load_sel", EX_FWD_SEL, 4'h1);
        drive(1, 5, 0, 5, 1, 0, 0, 1);
        chk("t5_flush_stall", STALL, 0);
        tick();
        chk("t5_flush_sel", EX_FWD_SEL, 0);
        // Flushed writer of x5 must not appear in EX: reader sees only the load at stage 2
        drive(1, 5, 0, 3, 0, 0, 0, 0);
        chk("t5_post_stall", STALL, 0);
        tick();
        chk("t5_post_sel", EX_FWD_SEL, 4'h2);
        idle(); tick();

        // Reset in the middle of a freeze clears outputs without a clock edge
        drive(1, 0, 0, 9, 1, 0, 0, 0); tick();
        drive(1, 9, 0, 8, 1, 0, 1, 0); tick();
        chk("t6_sel", EX_FWD_SEL, 4'h1);
        idle(); tick();
        chk("t6_freeze_cnt1", FREEZE, 1);
        #2 RESET = 1'b0;
        #1;
        chk("t6_rst_freeze", FREEZE, 0);
        chk("t6_rst_stall", STALL, 0);
        chk("t6_rst_sel", EX_FWD_SEL, 0);
        tick();
        tick();
        #3 RESET = 1'b1;
        drive(1, 8, 9, 3, 0, 0, 0, 0);
        chk("t6_post_stall", STALL, 0);
        tick();
        chk("t6_post_sel", EX_FWD_SEL, 0);
        chk("t6_post_freeze", FREEZE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
